// File: rtl/product.sv
`default_nettype none
// ============================================================================
//  Module   : product
//  Purpose  : Product/multiplier register for a 32x32 unsigned sequential
//             shift-add multiplier. Holds the 64-bit running product, shows
//             its upper half to the external ALU, and steps one add/shift
//             iteration per clock for 32 clocks after a load.
//  Option   : PRODUCT_DONE_EN - adds a one-cycle 'done' pulse output on the
//             first cycle in which the final product is available.
//  Revision : 1.0  initial release
// ============================================================================
module product (
    input  logic        clk,
    input  logic        rst,         // asynchronous, active-low
    input  logic        run,
    input  logic [31:0] Mul,
    input  logic [32:0] ALU_result,  // {carry, sum} of Hi + multiplicand
    output logic [31:0] Hi,
    output logic [63:0] Prod,
    output logic        counting
`ifdef PRODUCT_DONE_EN
    ,
    output logic        done
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [63:0] r_prod;
    logic        r_counting;

    logic [63:0] w_prod_step;
    logic        w_last;

    // One iteration: when the low multiplier bit is set, the ALU sum (with its
    // carry becoming bit 63) replaces the high half; either way shift right.
    always_comb begin
        w_prod_step = {1'b0, r_prod[63:1]};
        if (r_prod[0]) begin
            w_prod_step = {ALU_result, r_prod[31:1]};
        end
        w_last = (r_cnt == 6'd31);
    end

    // Control FSM plus product/counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 6'd0;
            r_prod     <= 64'd0;
            r_counting <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_prod     <= {32'd0, Mul};
                        r_cnt      <= 6'd0;
                        r_counting <= 1'b1;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_prod <= w_prod_step;
                    r_cnt  <= r_cnt + 6'd1;
                    if (w_last) begin
                        r_counting <= 1'b0;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    // run must drop before another operation can start
                    if (!run) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_counting <= 1'b0;
                end
            endcase
        end
    end

`ifdef PRODUCT_DONE_EN
    logic r_done;

    // Pulse high during the first DONE cycle only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_BUSY) && w_last;
        end
    end

    assign done = r_done;
`endif

    assign Hi       = r_prod[63:32];
    assign Prod     = r_prod;
    assign counting = r_counting;

endmodule
`default_nettype wire

// File: tb/tb_product.sv
`default_nettype none
// ============================================================================
//  Module   : tb_product
//  Purpose  : Directed self-checking bench for the product register.
//  Revision : 1.0  initial release
// ============================================================================
module tb_product;

    logic        clk;
    logic        rst;
    logic        run;
    logic [31:0] Mul;
    logic [32:0] ALU_result;
    logic [31:0] Hi;
    logic [63:0] Prod;
    logic        counting;
`ifdef PRODUCT_DONE_EN
    logic        done;
`endif

    // ALU source: either a directed constant or Hi + multiplicand
    logic        alu_auto;
    logic [32:0] alu_manual;
    logic [31:0] mcand;

    int n_cmp;
    int n_err;

    product dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .Mul        (Mul),
        .ALU_result (ALU_result),
        .Hi         (Hi),
        .Prod       (Prod),
        .counting   (counting)
`ifdef PRODUCT_DONE_EN
        ,
        .done       (done)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        ALU_result = alu_manual;
        if (alu_auto) begin
            ALU_result = {1'b0, Hi} + {1'b0, mcand};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, leave time at edge + 1
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2;
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    // Start from IDLE, load, iterate 32 times, check the product
    task automatic run_mul(input logic [31:0] mul, input logic [31:0] mc, input logic [63:0] exp);
        alu_auto = 1'b1;
        mcand    = mc;
        Mul      = mul;
        run      = 1'b1;
        tick();
        check("mul_load_prod", Prod, {32'd0, mul});
        check("mul_load_counting", {63'd0, counting}, 64'd1);
        Mul = ~mul;                       // must have no effect from here on
        repeat (31) tick();
        check("mul_iter31_counting", {63'd0, counting}, 64'd1);
        tick();
        check("mul_final_counting", {63'd0, counting}, 64'd0);
        check("mul_final_prod", Prod, exp);
`ifdef PRODUCT_DONE_EN
        check("mul_done_pulse", {63'd0, done}, 64'd1);
        tick();
        check("mul_done_clear", {63'd0, done}, 64'd0);
        check("mul_hold_after_done", Prod, exp);
`endif
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        run        = 1'b0;
        Mul        = 32'd0;
        alu_auto   = 1'b0;
        alu_manual = 33'd0;
        mcand      = 32'd0;

        // Reset values
        #2;
        check("rst_prod", Prod, 64'd0);
        check("rst_counting", {63'd0, counting}, 64'd0);
        check("rst_hi", {32'd0, Hi}, 64'd0);
        rst = 1'b1;
        tick();

        // Load then one add-shift step with carry into bit 63
        Mul = 32'h0000_0005;
        run = 1'b1;
        tick();
        check("load_prod", Prod, 64'h0000_0000_0000_0005);
        check("load_counting", {63'd0, counting}, 64'd1);
        run        = 1'b0;
        alu_manual = 33'h1_0000_0000;
        tick();
        check("addshift_prod", Prod, 64'h8000_0000_0000_0002);
        check("addshift_counting", {63'd0, counting}, 64'd1);

        // Asynchronous reset in the middle of an operation
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_prod", Prod, 64'd0);
        check("async_rst_counting", {63'd0, counting}, 64'd0);
        check("async_rst_hi", {32'd0, Hi}, 64'd0);
        rst = 1'b1;
        tick();

        // Build Prod = 0x0000000300000004 from Mul=9 and ALU=6, then shift-only
        Mul = 32'd9;
        run = 1'b1;
        tick();
        check("shift_load", Prod, 64'd9);
        run        = 1'b0;
        alu_manual = 33'd6;
        tick();
        check("shift_setup", Prod, 64'h0000_0003_0000_0004);
        check("shift_setup_hi", {32'd0, Hi}, 64'h3);
        alu_manual = 33'h1_2345_6789;
        tick();
        check("shift_only", Prod, 64'h0000_0001_8000_0002);
        pulse_reset();
        tick();

        // Full multiply 6 * 7
        run_mul(32'd6, 32'd7, 64'h0000_0000_0000_002A);

        // run held high in DONE: product must stay put
        repeat (3) tick();
        check("hold_prod", Prod, 64'h0000_0000_0000_002A);
        check("hold_counting", {63'd0, counting}, 64'd0);

        // Drop run for one cycle, product still held in IDLE
        run = 1'b0;
        tick();
        check("idle_prod", Prod, 64'h0000_0000_0000_002A);

        // Restart: max operands
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

        run = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
